// File: rtl/opb_master_single.sv
// Single-beat OPB master: turns one valid/ready command into a single OPB read or write
// and returns a one-cycle response strobe carrying read data and a completion code.
module opb_master_single #(
  parameter int    C_OPB_AWIDTH     = 32,
  parameter int    C_OPB_DWIDTH     = 32,
  parameter int    C_TIMEOUT_CYCLES = 16,
  parameter int    C_MAX_RETRY      = 4,
  parameter string C_FAMILY         = "virtex6"
) (
  input  logic                          OPB_Clk,
  input  logic                          OPB_Rst,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic                          cmd_rnw,
  input  logic [C_OPB_AWIDTH-1:0]       cmd_addr,
  input  logic [C_OPB_DWIDTH-1:0]       cmd_data,
  input  logic [C_OPB_DWIDTH/8-1:0]     cmd_be,
  output logic                          rsp_valid,
  output logic [C_OPB_DWIDTH-1:0]       rsp_data,
  output logic [1:0]                    rsp_status,
  output logic                          M_request,
  output logic                          M_select,
  output logic                          M_RNW,
  output logic [0:C_OPB_AWIDTH-1]       M_ABus,
  output logic [0:C_OPB_DWIDTH/8-1]     M_BE,
  output logic [0:C_OPB_DWIDTH-1]       M_DBus,
  output logic                          M_seqAddr,
  output logic                          M_busLock,
  input  logic                          OPB_MGrant,
  input  logic                          OPB_xferAck,
  input  logic                          OPB_errAck,
  input  logic                          OPB_retry,
  input  logic                          OPB_timeout,
  input  logic [0:C_OPB_DWIDTH-1]       OPB_DBus
);
  localparam int BEW = C_OPB_DWIDTH / 8;
  localparam logic [7:0] TMO_LAST  = 8'(C_TIMEOUT_CYCLES - 1);
  localparam logic [3:0] RETRY_MAX = 4'(C_MAX_RETRY);

  localparam logic [1:0] ST_OK    = 2'b00;
  localparam logic [1:0] ST_ERR   = 2'b01;
  localparam logic [1:0] ST_TMO   = 2'b10;
  localparam logic [1:0] ST_RETRY = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_XFER, S_RESP} state_t;

  state_t                    state_q, state_d;
  logic                      rnw_q, rnw_d;
  logic [C_OPB_AWIDTH-1:0]   addr_q, addr_d;
  logic [C_OPB_DWIDTH-1:0]   data_q, data_d;
  logic [BEW-1:0]            be_q, be_d;
  logic [3:0]                retry_q, retry_d;
  logic [7:0]                tmo_q, tmo_d;
  logic [C_OPB_DWIDTH-1:0]   rsp_data_q, rsp_data_d;
  logic [1:0]                rsp_status_q, rsp_status_d;

  logic                      rdy_q, rdy_d;
  logic                      rvld_q, rvld_d;
  logic                      req_q, req_d;
  logic                      sel_q, sel_d;
  logic                      mrnw_q, mrnw_d;
  logic [C_OPB_AWIDTH-1:0]   abus_q, abus_d;
  logic [BEW-1:0]            mbe_q, mbe_d;
  logic [C_OPB_DWIDTH-1:0]   dbus_q, dbus_d;

  always_comb begin
    state_d      = state_q;
    rnw_d        = rnw_q;
    addr_d       = addr_q;
    data_d       = data_q;
    be_d         = be_q;
    retry_d      = retry_q;
    tmo_d        = tmo_q;
    rsp_data_d   = rsp_data_q;
    rsp_status_d = rsp_status_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && rdy_q) begin
          rnw_d   = cmd_rnw;
          addr_d  = cmd_addr;
          data_d  = cmd_data;
          be_d    = cmd_be;
          retry_d = '0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (OPB_MGrant) begin
          tmo_d   = '0;
          state_d = S_XFER;
        end
      end
      S_XFER: begin
        tmo_d = tmo_q + 8'd1;
        // Exit priority: errAck, xferAck, retry, then bus/self timeout.
        if (OPB_errAck) begin
          rsp_status_d = ST_ERR;
          rsp_data_d   = '0;
          state_d      = S_RESP;
        end else if (OPB_xferAck) begin
          rsp_status_d = ST_OK;
          rsp_data_d   = rnw_q ? OPB_DBus : '0;
          state_d      = S_RESP;
        end else if (OPB_retry) begin
          if (retry_q < RETRY_MAX) begin
            retry_d = retry_q + 4'd1;
            state_d = S_REQ;
          end else begin
            rsp_status_d = ST_RETRY;
            rsp_data_d   = '0;
            state_d      = S_RESP;
          end
        end else if (OPB_timeout || (tmo_q == TMO_LAST)) begin
          rsp_status_d = ST_TMO;
          rsp_data_d   = '0;
          state_d      = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Bus outputs are registered from the next state so they stay zero outside select.
    rdy_d  = (state_d == S_IDLE);
    rvld_d = (state_d == S_RESP);
    req_d  = (state_d == S_REQ);
    sel_d  = (state_d == S_XFER);
    mrnw_d = sel_d & rnw_q;
    abus_d = sel_d ? addr_q : '0;
    mbe_d  = sel_d ? be_q : '0;
    dbus_d = (sel_d && !rnw_q) ? data_q : '0;
  end

  always_ff @(posedge OPB_Clk) begin
    if (!OPB_Rst) begin
      state_q      <= S_IDLE;
      retry_q      <= '0;
      tmo_q        <= '0;
      rsp_data_q   <= '0;
      rsp_status_q <= '0;
      rdy_q        <= 1'b0;
      rvld_q       <= 1'b0;
      req_q        <= 1'b0;
      sel_q        <= 1'b0;
      mrnw_q       <= 1'b0;
      abus_q       <= '0;
      mbe_q        <= '0;
      dbus_q       <= '0;
    end else begin
      state_q      <= state_d;
      retry_q      <= retry_d;
      tmo_q        <= tmo_d;
      rsp_data_q   <= rsp_data_d;
      rsp_status_q <= rsp_status_d;
      rdy_q        <= rdy_d;
      rvld_q       <= rvld_d;
      req_q        <= req_d;
      sel_q        <= sel_d;
      mrnw_q       <= mrnw_d;
      abus_q       <= abus_d;
      mbe_q        <= mbe_d;
      dbus_q       <= dbus_d;
    end
  end

  // Latched command only matters once a command is accepted, so it needs no reset.
  always_ff @(posedge OPB_Clk) begin
    rnw_q  <= rnw_d;
    addr_q <= addr_d;
    data_q <= data_d;
    be_q   <= be_d;
  end

  // Direct assignment to the ascending-range buses maps user bit i onto bus bit (W-1-i).
  assign cmd_ready  = rdy_q;
  assign rsp_valid  = rvld_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_status = rsp_status_q;
  assign M_request  = req_q;
  assign M_select   = sel_q;
  assign M_RNW      = mrnw_q;
  assign M_ABus     = abus_q;
  assign M_BE       = mbe_q;
  assign M_DBus     = dbus_q;
  assign M_seqAddr  = 1'b0;
  assign M_busLock  = 1'b0;
endmodule

// File: tb/tb_opb_master_single.sv
// Scoreboard bench for opb_master_single: a scripted OPB slave/arbiter, a response monitor
// and directed commands with hand-computed expected results.
`timescale 1ns/1ps
module tb_opb_master_single;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_rnw;
  logic [31:0] cmd_addr, cmd_data;
  logic [3:0]  cmd_be;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_status;
  logic        M_request, M_select, M_RNW, M_seqAddr, M_busLock;
  logic [0:31] M_ABus, M_DBus;
  logic [0:3]  M_BE;
  logic        OPB_MGrant, OPB_xferAck, OPB_errAck, OPB_retry, OPB_timeout;
  logic [0:31] OPB_DBus;

  always #5 clk = ~clk;

  opb_master_single #(.C_TIMEOUT_CYCLES(16), .C_MAX_RETRY(4)) dut (
    .OPB_Clk(clk), .OPB_Rst(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rnw(cmd_rnw),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_be(cmd_be),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_status(rsp_status),
    .M_request(M_request), .M_select(M_select), .M_RNW(M_RNW),
    .M_ABus(M_ABus), .M_BE(M_BE), .M_DBus(M_DBus),
    .M_seqAddr(M_seqAddr), .M_busLock(M_busLock),
    .OPB_MGrant(OPB_MGrant), .OPB_xferAck(OPB_xferAck), .OPB_errAck(OPB_errAck),
    .OPB_retry(OPB_retry), .OPB_timeout(OPB_timeout), .OPB_DBus(OPB_DBus)
  );

  typedef struct {
    logic [1:0]  st;
    logic [31:0] dat;
    int          sel;
    int          req;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  // Slave script: grant delay, mode (0 ack, 1 err+ack, 2 retry, 3 silent, 4 bus timeout), wait states.
  int          s_gdly, s_mode, s_wait;
  logic [0:31] s_dat;
  logic        exp_rnw;
  logic [0:31] exp_abus, exp_dbus;
  logic [0:3]  exp_be;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  initial begin
    int gcnt;
    int scnt;
    gcnt = 0;
    scnt = 0;
    OPB_MGrant = 0; OPB_xferAck = 0; OPB_errAck = 0;
    OPB_retry = 0; OPB_timeout = 0; OPB_DBus = '0;
    forever begin
      @(negedge clk);
      OPB_MGrant = 0; OPB_xferAck = 0; OPB_errAck = 0;
      OPB_retry = 0; OPB_timeout = 0; OPB_DBus = '0;
      if (M_request) begin
        if (gcnt == s_gdly) begin
          OPB_MGrant = 1;
          gcnt = 0;
        end else gcnt++;
      end else gcnt = 0;
      if (M_select) begin
        scnt++;
        if (scnt == s_wait + 1) begin
          case (s_mode)
            0: begin OPB_xferAck = 1; OPB_DBus = s_dat; end
            1: begin OPB_xferAck = 1; OPB_errAck = 1; OPB_DBus = s_dat; end
            2: OPB_retry = 1;
            4: OPB_timeout = 1;
            default: ;
          endcase
        end
      end else scnt = 0;
    end
  end

  initial begin
    int   sel_n;
    int   req_n;
    logic req_prev;
    exp_t e;
    sel_n = 0;
    req_n = 0;
    req_prev = 0;
    forever begin
      @(negedge clk);
      if (cmd_ready) begin
        sel_n = 0;
        req_n = 0;
      end
      if (M_request && !req_prev) req_n++;
      req_prev = M_request;
      if (M_select) begin
        sel_n++;
        chk("sel_abus", M_ABus, exp_abus);
        chk("sel_be", 32'(M_BE), 32'(exp_be));
        chk("sel_rnw", 32'(M_RNW), 32'(exp_rnw));
        chk("sel_dbus", M_DBus, exp_dbus);
      end else begin
        chk("orbus_idle", 32'(|{M_ABus, M_BE, M_DBus, M_RNW}), 32'd0);
      end
      if (rsp_valid) begin
        if (sb.size() == 0) chk("unexpected_rsp", 32'd1, 32'd0);
        else begin
          e = sb.pop_front();
          chk("rsp_status", 32'(rsp_status), 32'(e.st));
          chk("rsp_data", rsp_data, e.dat);
          chk("select_cycles", 32'(sel_n), 32'(e.sel));
          chk("request_count", 32'(req_n), 32'(e.req));
        end
      end
    end
  end

  task automatic issue(input logic rnw, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    int n;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) chk("cmd_ready_wait", 32'd0, 32'd1);
    cmd_valid = 1; cmd_rnw = rnw; cmd_addr = a; cmd_data = d; cmd_be = be;
    @(negedge clk);
    cmd_valid = 0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk("rsp_wait", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  task automatic run(input logic rnw, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                     input int gd, input int md, input int wt, input logic [31:0] sd,
                     input logic [31:0] edbus, input logic [1:0] est, input logic [31:0] edat,
                     input int esel, input int ereq);
    exp_t e;
    s_gdly = gd; s_mode = md; s_wait = wt; s_dat = sd;
    exp_rnw = rnw; exp_abus = a; exp_be = be; exp_dbus = edbus;
    e.st = est; e.dat = edat; e.sel = esel; e.req = ereq;
    sb.push_back(e);
    issue(rnw, a, d, be);
    wait_done();
  endtask

  initial begin
    exp_t e;
    int   n;
    rst_n = 0; cmd_valid = 0; cmd_rnw = 0; cmd_addr = '0; cmd_data = '0; cmd_be = '0;
    s_gdly = 0; s_mode = 0; s_wait = 0; s_dat = '0;
    exp_rnw = 0; exp_abus = '0; exp_be = '0; exp_dbus = '0;
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_request", 32'(M_request), 32'd0);
    chk("rst_select", 32'(M_select), 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_rsp_status", 32'(rsp_status), 32'd0);
    rst_n = 1;
    @(negedge clk);
    chk("cmd_ready_after_rst", 32'(cmd_ready), 32'd1);

    // Write, grant after 2 cycles, ack on first select cycle.
    run(1'b0, 32'h010C0100, 32'hDEADBEEF, 4'hF, 2, 0, 0, 32'h0,
        32'hDEADBEEF, 2'b00, 32'h0, 1, 1);
    // Read with 3 wait states.
    run(1'b1, 32'h010C0104, 32'h0, 4'hF, 0, 0, 3, 32'h12345678,
        32'h0, 2'b00, 32'h12345678, 4, 1);
    repeat (3) @(negedge clk);
    chk("hold_rsp_data", rsp_data, 32'h12345678);
    chk("hold_rsp_status", 32'(rsp_status), 32'd0);
    // Retry every select phase: 5 phases then retry-limit failure.
    run(1'b1, 32'h00000040, 32'h0, 4'h3, 1, 2, 0, 32'hA5A5A5A5,
        32'h0, 2'b11, 32'h0, 5, 5);
    // Silent slave: self-timeout after 16 select cycles.
    run(1'b0, 32'h00000080, 32'h11112222, 4'h1, 0, 3, 0, 32'h0,
        32'h11112222, 2'b10, 32'h0, 16, 1);
    // Arbiter timeout on the third select cycle.
    run(1'b1, 32'h000000C0, 32'h0, 4'hC, 0, 4, 2, 32'h0,
        32'h0, 2'b10, 32'h0, 3, 1);
    // errAck together with xferAck on a read.
    run(1'b1, 32'h010C0108, 32'h0, 4'hF, 0, 1, 0, 32'hCAFEF00D,
        32'h0, 2'b01, 32'h0, 1, 1);

    // Reset in the middle of a transfer: no response, all outputs cleared.
    s_gdly = 0; s_mode = 3; s_wait = 0; s_dat = '0;
    exp_rnw = 0; exp_abus = 32'h00000020; exp_be = 4'hF; exp_dbus = 32'h5555AAAA;
    issue(1'b0, 32'h00000020, 32'h5555AAAA, 4'hF);
    n = 0;
    while (!M_select && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("xfer_reached", 32'(M_select), 32'd1);
    @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    chk("midrst_select", 32'(M_select), 32'd0);
    chk("midrst_request", 32'(M_request), 32'd0);
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("midrst_abus", M_ABus, 32'd0);
    rst_n = 1;
    @(negedge clk);
    chk("cmd_ready_after_midrst", 32'(cmd_ready), 32'd1);

    // Best-case zero-wait write after reset, with response/ready timing.
    s_gdly = 0; s_mode = 0; s_wait = 0; s_dat = '0;
    exp_rnw = 0; exp_abus = 32'h00000004; exp_be = 4'h3; exp_dbus = 32'h0000A5A5;
    e.st = 2'b00; e.dat = 32'h0; e.sel = 1; e.req = 1;
    sb.push_back(e);
    issue(1'b0, 32'h00000004, 32'h0000A5A5, 4'h3);
    repeat (2) @(negedge clk);
    chk("best_rsp_valid", 32'(rsp_valid), 32'd1);
    @(negedge clk);
    chk("best_cmd_ready", 32'(cmd_ready), 32'd1);
    wait_done();

    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/opb_master_single.md
# opb_master_single

Single-beat OPB bus master that turns a simple valid/ready command from user fabric into one OPB read or write, then returns a response with read data and a completion status. It sits beside the OPB slave registers on the same bus. It lets fabric logic read and write slave register space, for example status and control registers, without the PPC. Only one transaction is outstanding at a time. Bursts, sequential addressing and bus locking are not supported.

## Interface
- C_OPB_AWIDTH, 32, OPB address width.
- C_OPB_DWIDTH, 32, OPB data width.
- C_TIMEOUT_CYCLES, 16, maximum cycles `M_select` is held without an acknowledge before the master aborts itself (range 2–255).
- C_MAX_RETRY, 4, number of `OPB_retry` re-issues allowed before the command fails (range 0–15).
- C_FAMILY, "virtex6", target family. Informational only.

Ports:
- OPB_Clk  in  1  OPB clock. Every register in the block uses its rising edge.
- OPB_Rst  in  1  reset, synchronous and active-low: 0 resets the block.
- cmd_valid  in  1  a command is presented.
- cmd_ready  out  1  the block can accept a command.
- cmd_rnw  in  1  1 = read, 0 = write.
- cmd_addr  in  [31:0]  byte address.
- cmd_data  in  [31:0]  write data.
- cmd_be  in  [3:0]  byte enables.
- rsp_valid  out  1  one-cycle completion strobe.
- rsp_data  out  [31:0]  read data; 0 for writes and for failed commands.
- rsp_status  out  [1:0]  completion code: 00 OK, 01 errAck, 10 timeout, 11 retry limit exhausted.
- M_request  out  1  bus request.
- M_select  out  1  transfer in progress.
- M_RNW  out  1  read/not-write.
- M_ABus  out  [0:31]  address.
- M_BE  out  [0:3]  byte enables.
- M_DBus  out  [0:31]  write data.
- M_seqAddr  out  1  tied 0.
- M_busLock  out  1  tied 0.
- OPB_MGrant  in  1  bus grant.
- OPB_xferAck  in  1  slave transfer acknowledge.
- OPB_errAck  in  1  slave error acknowledge.
- OPB_retry  in  1  slave retry request.
- OPB_timeout  in  1  arbiter bus timeout.
- OPB_DBus  in  [0:31]  read data.

## Operation
- Bit mapping: user bit i drives bus bit (31−i). For example, `cmd_addr[31]` drives `M_ABus[0]` and `cmd_be[3]` drives `M_BE[0]`. `rsp_data` uses the same mapping from `OPB_DBus`.
- States: IDLE, REQ, XFER, RESP.
- IDLE:
  - `cmd_ready`=1.
  - When `cmd_valid` and `cmd_ready` are both high, latch rnw/addr/data/be, clear the retry count, and go to REQ.
- REQ:
  - `M_request`=1.
  - When `OPB_MGrant` is sampled high, go to XFER and clear the timeout counter.
- XFER:
  - `M_select`=1 and `M_request`=0.
  - `M_ABus`, `M_BE` and `M_RNW` are driven from the latched command.
  - `M_DBus` carries the latched data only for writes.
  - The timeout counter increments every cycle. Exit conditions, in priority order:
    - `OPB_errAck`: status 01, go to RESP.
    - `OPB_xferAck`: status 00, capture `OPB_DBus` if the command is a read, go to RESP.
    - `OPB_retry`:
      - If retry count < C_MAX_RETRY: increment it and go to REQ.
      - Otherwise: status 11, go to RESP.
    - `OPB_timeout`, or the counter equals C_TIMEOUT_CYCLES−1: status 10, go to RESP.
- RESP: `rsp_valid`=1 for exactly one cycle, then go to IDLE.
- OR-bus rule: whenever `M_select`=0, `M_ABus`, `M_BE`, `M_DBus` and `M_RNW` are all 0. All M_* outputs are registered.
- `rsp_data` and `rsp_status` are held stable until the next completion. `rsp_data` is forced to 0 when status ≠ 00.
- Only one command is accepted per transaction. Any `cmd_valid` outside IDLE is ignored because `cmd_ready` is 0.

## Timing
- Reset (`OPB_Rst`=0 sampled at an edge): on the following cycle every output is 0, including `cmd_ready`, `rsp_data` and `rsp_status`, and the state is IDLE.
  - `cmd_ready` goes to 1 on the first cycle after reset is released.
  - A reset in the middle of a transaction drops `M_select` and `M_request` on the next cycle and produces no response.
- Command accepted at edge N: `M_request`=1 from cycle N+1.
- `OPB_MGrant` sampled at edge G: `M_select`=1 from G+1, and `M_request` falls on the same cycle.
- Acknowledge sampled at edge A: `M_select`=0 and `rsp_valid`=1 at A+1; `cmd_ready`=1 at A+2.
- Best case, zero-wait grant and slave (grant sampled at edge N+1, acknowledge sampled at edge N+2): `rsp_valid` at N+3, and the next command can be accepted at N+4.
- Retry: `M_select` is low for at least one cycle before `M_request` is reasserted (cycle A+1).
- Self-timeout: `M_select` is high for exactly C_TIMEOUT_CYCLES cycles, then `rsp_valid` follows on the next cycle.
- Any acknowledge sampled in REQ or RESP is ignored.

## Test plan
- Write, addr 0x010C0100, data 0xDEADBEEF, be 0xF, grant after 2 cycles, xferAck on the first select cycle → `M_ABus`=0x010C0100 and `M_DBus`=0xDEADBEEF while `M_select` is high, then `rsp_status`=00.
- Read, addr 0x010C0104, slave returns 0x12345678 with 3 wait cycles → `rsp_data`=0x12345678, status 00, `M_select` high for 4 cycles, and `M_DBus`=0 throughout.
- Slave asserts `OPB_retry` 5 times with C_MAX_RETRY=4 → 5 select phases, 5 requests, status 11, and `rsp_data`=0.
- No acknowledge with C_TIMEOUT_CYCLES=16 → `M_select` high for exactly 16 cycles, status 10; a separate run with `OPB_timeout` at cycle 3 gives status 10 after 3 cycles.
- `OPB_errAck` and `OPB_xferAck` asserted together on a read → status 01 and `rsp_data`=0.
- `OPB_Rst`=0 during XFER → all outputs 0 on the next cycle, no `rsp_valid`, and a new command is accepted normally after reset is released.
